// File: rtl/character_transmission_if.sv
// character_transmission_if: parallel-in handshake and serial-out signals of the UART-lite transmitter.
interface character_transmission_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] char_i;
    logic                 valid_i;
    logic                 ready_o;
    logic                 tx_o;
    logic                 busy_o;
    modport master (output char_i, valid_i, input ready_o, tx_o, busy_o);
    modport slave  (input char_i, valid_i, output ready_o, tx_o, busy_o);
endinterface

// File: rtl/character_transmission.sv
// character_transmission: UART-lite serial transmitter (start, LSB-first data, stop bits).
// Define UART_TX_PARITY_EN to insert a parity bit between the data and stop bits.
module character_transmission #(
    parameter int OVERSAMPLING  = 16,
    parameter bit IDLE_POLARITY = 1'b1,
    parameter int DATA_BITS     = 8,
    parameter int STOP_BITS     = 1,
    parameter int PARITY_ODD    = 0
) (
    input  logic clk_i,
    input  logic rst_i,
    character_transmission_if.slave bus
);
    localparam int CW = $clog2(OVERSAMPLING);
    localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] RELOAD   = CW'(OVERSAMPLING - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);
    localparam logic          LAST_STOP = (STOP_BITS == 2);

    if (OVERSAMPLING < 2) begin : g_bad_os
        $error("OVERSAMPLING must be at least 2");
    end
    if (DATA_BITS < 1 || DATA_BITS > 16) begin : g_bad_db
        $error("DATA_BITS must be in 1..16");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_sb
        $error("STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_po
        $error("PARITY_ODD must be 0 or 1");
    end

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
    logic r_par, w_par;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t               r_state, w_state;
    logic [CW-1:0]        r_cnt, w_cnt;
    logic [IW-1:0]        r_idx, w_idx;
    logic                 r_stop, w_stop;
    logic [DATA_BITS-1:0] r_shift, w_shift;
    logic                 r_tx, w_tx;
    logic                 r_busy, w_busy;
    logic                 w_tick, w_ready, w_accept;

    always_comb begin
        w_tick   = (r_cnt == '0);
        w_ready  = !rst_i && (r_state == S_IDLE || (r_state == S_STOP && w_tick && r_stop == LAST_STOP));
        w_accept = bus.valid_i && w_ready;
        w_state  = r_state;
        w_cnt    = w_tick ? r_cnt : r_cnt - 1'b1;
        w_idx    = r_idx;
        w_stop   = r_stop;
        w_shift  = r_shift;
        w_tx     = r_tx;
        w_busy   = r_busy;
`ifdef UART_TX_PARITY_EN
        w_par    = r_par;
`endif
        case (r_state)
            S_IDLE: begin
                w_tx   = IDLE_POLARITY;
                w_busy = 1'b0;
            end
            S_START: if (w_tick) begin
                w_tx    = r_shift[0];
                w_shift = r_shift >> 1;
                w_cnt   = RELOAD;
                w_idx   = '0;
                w_state = S_DATA;
            end
            S_DATA: if (w_tick && r_idx != LAST_IDX) begin
                w_tx    = r_shift[0];
                w_shift = r_shift >> 1;
                w_idx   = r_idx + 1'b1;
                w_cnt   = RELOAD;
            end else if (w_tick) begin
                w_cnt   = RELOAD;
`ifdef UART_TX_PARITY_EN
                w_tx    = r_par;
                w_state = S_PARITY;
            end
            S_PARITY: if (w_tick) begin
                w_cnt   = RELOAD;
`endif
                w_tx    = IDLE_POLARITY;
                w_stop  = 1'b0;
                w_state = S_STOP;
            end
            S_STOP: if (w_tick && r_stop != LAST_STOP) begin
                w_stop = 1'b1;
                w_cnt  = RELOAD;
            end else if (w_tick) begin
                w_tx    = IDLE_POLARITY;
                w_busy  = 1'b0;
                w_state = S_IDLE;
            end
            default: w_state = S_IDLE;
        endcase
        // An accept on the final stop cycle chains straight into the next start bit.
        if (w_accept) begin
            w_shift = bus.char_i;
            w_cnt   = RELOAD;
            w_tx    = !IDLE_POLARITY;
            w_busy  = 1'b1;
            w_state = S_START;
`ifdef UART_TX_PARITY_EN
            w_par   = (^bus.char_i) ^ PARITY_ODD[0];
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_stop  <= 1'b0;
            r_shift <= '0;
            r_tx    <= IDLE_POLARITY;
            r_busy  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_idx   <= w_idx;
            r_stop  <= w_stop;
            r_shift <= w_shift;
            r_tx    <= w_tx;
            r_busy  <= w_busy;
`ifdef UART_TX_PARITY_EN
            r_par   <= w_par;
`endif
        end
    end

    assign bus.ready_o = w_ready;
    assign bus.tx_o    = r_tx;
    assign bus.busy_o  = r_busy;
endmodule

// File: tb/tb_character_transmission.sv
// tb_character_transmission: checks a default and a small-parameter transmitter against a frame-position model.
module tb_character_transmission;
    localparam int OS_A = 16, DB_A = 8, SB_A = 1;
    localparam bit IP_A = 1'b1;
    localparam int OS_B = 3, DB_B = 5, SB_B = 2;
    localparam bit IP_B = 1'b0;
    localparam int PO = 0;
`ifdef UART_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int L_A = (1 + DB_A + PB + SB_A) * OS_A;
    localparam int L_B = (1 + DB_B + PB + SB_B) * OS_B;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    character_transmission_if #(.DATA_BITS(DB_A)) bus_a ();
    character_transmission_if #(.DATA_BITS(DB_B)) bus_b ();

    character_transmission dut_a (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus_a)
    );

    character_transmission #(
        .OVERSAMPLING (OS_B),
        .IDLE_POLARITY(IP_B),
        .DATA_BITS    (DB_B),
        .STOP_BITS    (SB_B),
        .PARITY_ODD   (PO)
    ) dut_b (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus_b)
    );

    assign bus_b.char_i  = bus_a.char_i[DB_B-1:0];
    assign bus_b.valid_i = bus_a.valid_i;

    int tot = 0;
    int bad = 0;
    int cyc = 0;
    int fs_a = -1, fs_b = -1;
    int unsigned ch_a = 0, ch_b = 0;
    bit en = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tot++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Level of bit slot b of a frame: start, data LSB first, optional parity, then stop.
    function automatic logic frame_bit(input int unsigned ch, input int b, input int db, input logic ip);
        if (b == 0) return !ip;
        if (b <= db) return ch[b-1];
`ifdef UART_TX_PARITY_EN
        if (b == db + 1) return (^ch) ^ PO[0];
`endif
        return ip;
    endfunction

    function automatic bit can_take(input int fs, input int c, input int l);
        return fs < 0 || c - fs >= l - 1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            fs_a = -1;
            fs_b = -1;
            en = 1'b1;
        end else begin
            if (bus_a.valid_i && can_take(fs_a, cyc, L_A)) begin
                fs_a = cyc + 1;
                ch_a = 32'(bus_a.char_i);
            end
            if (bus_b.valid_i && can_take(fs_b, cyc, L_B)) begin
                fs_b = cyc + 1;
                ch_b = 32'(bus_b.char_i);
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (en) begin
            automatic bit ba = fs_a >= 0 && cyc - fs_a < L_A;
            automatic bit bb = fs_b >= 0 && cyc - fs_b < L_B;
            chk("a_ready", 32'(bus_a.ready_o), 32'(!rst && can_take(fs_a, cyc, L_A)));
            chk("a_busy", 32'(bus_a.busy_o), 32'(ba));
            chk("a_tx", 32'(bus_a.tx_o), 32'(ba ? frame_bit(ch_a, (cyc - fs_a) / OS_A, DB_A, IP_A) : IP_A));
            chk("b_ready", 32'(bus_b.ready_o), 32'(!rst && can_take(fs_b, cyc, L_B)));
            chk("b_busy", 32'(bus_b.busy_o), 32'(bb));
            chk("b_tx", 32'(bus_b.tx_o), 32'(bb ? frame_bit(ch_b, (cyc - fs_b) / OS_B, DB_B, IP_B) : IP_B));
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    initial begin
        bus_a.valid_i = 1'b0;
        bus_a.char_i  = '0;
        repeat (3) step();
        rst = 1'b0;
        step();
        bus_a.valid_i = 1'b1;
        bus_a.char_i  = 8'hA5;
        step();
        bus_a.valid_i = 1'b0;
        bus_a.char_i  = 8'h00;
        repeat (170) step();
        bus_a.valid_i = 1'b1;
        repeat (100) step();
        bus_a.char_i = 8'hFF;
        repeat (150) step();
        bus_a.valid_i = 1'b0;
        repeat (200) step();
        bus_a.valid_i = 1'b1;
        bus_a.char_i  = 8'h00;
        step();
        bus_a.valid_i = 1'b0;
        repeat (49) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (200) step();
        for (int i = 0; i < 4000; i++) begin
            bus_a.valid_i = 1'($urandom);
            bus_a.char_i  = 8'($urandom);
            rst = ($urandom_range(0, 699) == 0);
            step();
        end
        rst = 1'b0;
        bus_a.valid_i = 1'b0;
        repeat (200) step();
        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end
endmodule

// File: doc/character_transmission.md
Name: character_transmission

Overview:
UART-lite serial transmitter, the transmit-side counterpart of the receiver in uart_lite.
- Accepts one parallel character per valid/ready handshake.
- Serialises it as start bit, DATA_BITS data bits (LSB first), then STOP_BITS stop bits.
- Each bit is held for exactly OVERSAMPLING clk_i cycles, so the block runs on the same clock and bit-period parameters as the receiver.

Parameters:
- OVERSAMPLING, 16: clk_i cycles per bit period; legal range >= 2.
- IDLE_POLARITY, 1: line level while idle and during stop bits; the start bit is the inverse level.
- DATA_BITS, 8: data bits per character; legal range 1..16.
- STOP_BITS, 1: number of stop-bit periods; legal values 1 or 2.
- PARITY_ODD, 0: parity sense. 0 = even, 1 = odd. Only meaningful when UART_TX_PARITY_EN is defined.

Ports:
- clk_i, input, 1: system clock; all logic is on the rising edge.
- rst_i, input, 1: reset, synchronous, active-high.
- char_i, input, DATA_BITS: character to transmit; sampled only on the accept edge.
- valid_i, input, 1: char_i holds a character to send.
- ready_o, output, 1: block can accept a character this cycle.
- tx_o, output, 1: serial line out (registered).
- busy_o, output, 1: a frame is in progress (registered).

Behaviour:
- Clock and reset: one clock domain, clk_i. rst_i is synchronous and active-high.
- Reset:
  - state = IDLE, tx_o = IDLE_POLARITY, busy_o = 0, bit counter = 0.
  - ready_o is forced 0 while rst_i is high and is 1 on the first cycle after release.
  - valid_i is ignored while rst_i is high.
  - Reset mid-frame aborts the frame: tx_o returns to IDLE_POLARITY on the next edge and no partial bits are emitted afterwards.
- Accept:
  - A transfer occurs on a rising edge where valid_i && ready_o.
  - On that edge char_i is latched into a shift register, the counter is loaded with OVERSAMPLING-1, tx_o is set to !IDLE_POLARITY, and busy_o is set to 1.
  - The start bit therefore appears on the cycle after accept.
- States:
  - IDLE: tx_o = IDLE_POLARITY, ready_o = 1. Go to START on accept.
  - START: hold tx_o; the counter decrements each cycle. When the counter reaches 0: drive data bit 0, reload OVERSAMPLING-1, index = 0, go to DATA.
  - DATA: when the counter reaches 0 and index < DATA_BITS-1: shift, drive the next bit, index+1, reload the counter. When the counter reaches 0 and index == DATA_BITS-1: drive IDLE_POLARITY, reload the counter, stop count = 0, go to STOP (or PARITY when that option is enabled).
  - STOP: stays for STOP_BITS periods. When the counter reaches 0 on the last stop period: go to IDLE, busy_o = 0, unless a new accept occurs on that same edge.
- Timing:
  - Each bit lasts exactly OVERSAMPLING cycles, with no cumulative drift.
  - Frame length = (1 + DATA_BITS + STOP_BITS) * OVERSAMPLING cycles.
- Back-to-back:
  - ready_o is combinational. It is high in IDLE, and also high in STOP when the counter is 0 on the last stop period.
  - An accept on that last stop cycle goes directly to START with zero idle gap, and busy_o stays 1.
  - ready_o is 0 in all other states and cycles.
- Stability: char_i and valid_i changes outside the accept edge have no effect on tx_o.
- Widths:
  - Counter width is $clog2(OVERSAMPLING).
  - Index width is $clog2(DATA_BITS), minimum 1 bit.
  - Decrements and reloads are truncated to the counter width; the counter never wraps below 0 within a state.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- When defined:
  - A PARITY state of one OVERSAMPLING period is inserted between DATA and STOP.
  - tx_o carries the XOR of the latched char bits, XORed with PARITY_ODD.
  - Frame length grows by OVERSAMPLING cycles.
  - The parity bit is computed from the latched character, not from char_i.
- When undefined: no PARITY state and no parity logic; PARITY_ODD is unused.

Test Plan:
- Single frame (defaults, OVERSAMPLING=16, DATA_BITS=8): reset, then send 0xA5 accepted at edge 0.
  - tx_o = 0 for cycles 1-16.
  - Data bits 1,0,1,0,0,1,0,1 follow, 16 cycles each, cycles 17-144.
  - tx_o = 1 for cycles 145-160.
  - ready_o = 1 only on cycle 160 of the frame; busy_o = 0 from cycle 161.
- Back-to-back: hold valid_i = 1 with 0x00, then 0xFF.
  - The second start bit begins on cycle 161 with no gap.
  - tx_o shows 16x0 start + 128x0 data + 16x1 stop + 16x0 start + 128x1 data + 16x1 stop.
- Mid-frame reset: assert rst_i for 1 cycle at cycle 50 of a 0x00 frame.
  - tx_o = 1 from the following edge.
  - ready_o = 0 during reset and 1 the cycle after.
  - No further low bits appear.
- Ignored inputs: toggle char_i and valid_i every cycle while busy_o = 1.
  - The frame matches the originally latched character exactly.
  - No extra accepts occur, checked against ready_o.
- Parameter sweep: OVERSAMPLING=3, IDLE_POLARITY=0, DATA_BITS=5, STOP_BITS=2, send 0x13.
  - tx_o = 1 for 3 cycles (start), then bits 1,1,0,0,1 at 3 cycles each, then 0 for 6 cycles.
  - Frame is 24 cycles in total.
- Parity option (UART_TX_PARITY_EN defined):
  - PARITY_ODD = 0, send 0x07: parity bit = 1.
  - PARITY_ODD = 1, send 0x07: parity bit = 0.
  - Frame = 176 cycles at defaults.
  - Check that a loopback into the receiver yields valid_o = 1 with char_o = 0x07.
